// File: rtl/reg_alu_datapath_pkg.sv
// ---------------------------------------------------------------------------
// reg_alu_datapath_pkg
//   Shared definitions for the register-to-register execution datapath:
//   the default data width, the register-index width and the ALU operation
//   encodings driven on alu_control by the control unit.
// ---------------------------------------------------------------------------
package reg_alu_datapath_pkg;

  // Default data width of registers and ALU.
  localparam int XLEN = 32;

  // Default number of architectural registers.
  localparam int NREGS = 32;

  // Register-number ports are always 5 bits wide.
  localparam int REG_IDX_W = 5;

  // Width of the ALU operation select.
  localparam int ALU_OP_W = 4;

  // ALU operation encodings. Codes not listed here produce a zero result.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_NOR  = 4'b1100
  } alu_op_e;

endpackage : reg_alu_datapath_pkg

// File: rtl/reg_alu_datapath_regfile.sv
// ---------------------------------------------------------------------------
// dp_regfile
//   NREGS x XLEN architectural register file with two asynchronous read
//   ports and one synchronous write port.
//
//   Ports:
//     clock          rising-edge clock
//     reset          synchronous, active-low; loads register i with value i
//     read_reg_num1  read port 1 index
//     read_reg_num2  read port 2 index
//     read_data1     read port 1 data (combinational)
//     read_data2     read port 2 data (combinational)
//     write_reg      write port index
//     write_data     write port data
//     write_en       write enable, sampled on the rising edge
//
//   x0 is hardwired to zero on both read ports and ignores writes. Reads do
//   not bypass a write in flight: the old value is seen until the edge.
// ---------------------------------------------------------------------------
module dp_regfile
  import reg_alu_datapath_pkg::*;
#(
  parameter int XLEN  = reg_alu_datapath_pkg::XLEN,
  parameter int NREGS = reg_alu_datapath_pkg::NREGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] read_reg_num1,
  input  logic [REG_IDX_W-1:0] read_reg_num2,
  output logic [XLEN-1:0]      read_data1,
  output logic [XLEN-1:0]      read_data2,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic [XLEN-1:0]      write_data,
  input  logic                 write_en
);

  logic [XLEN-1:0] regs [NREGS];

  // Reset has priority over a pending write-back. The reset image (index
  // value in each register) gives the bench known operands without needing
  // a load path.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= XLEN'(i);
      end
    end else if (write_en && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

  // x0 is forced to zero at the read mux so its storage content never
  // matters.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg_num1 != '0) begin
      read_data1 = regs[read_reg_num1];
    end
    if (read_reg_num2 != '0) begin
      read_data2 = regs[read_reg_num2];
    end
  end

endmodule : dp_regfile

// File: rtl/reg_alu_datapath.sv
// ---------------------------------------------------------------------------
// reg_alu_datapath
//   Register-to-register execution datapath: the register file feeds a
//   combinational ALU whose result is written back to the register file on
//   the rising clock edge when regwrite is set.
//
//   Ports:
//     clock          rising-edge clock
//     reset          synchronous, active-low; registers return to x[i] = i
//     read_reg_num1  rs1 index (ALU operand A)
//     read_reg_num2  rs2 index (ALU operand B)
//     write_reg      rd index (write-back destination, x0 ignored)
//     alu_control    ALU operation select (see alu_op_e)
//     regwrite       write-back enable
//     zero_flag      high while the ALU result is zero (combinational)
// ---------------------------------------------------------------------------
module reg_alu_datapath
  import reg_alu_datapath_pkg::*;
#(
  parameter int XLEN  = reg_alu_datapath_pkg::XLEN,
  parameter int NREGS = reg_alu_datapath_pkg::NREGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] read_reg_num1,
  input  logic [REG_IDX_W-1:0] read_reg_num2,
  input  logic [REG_IDX_W-1:0] write_reg,
  input  logic [ALU_OP_W-1:0]  alu_control,
  input  logic                 regwrite,
  output logic                 zero_flag
);

  // Shift amounts use only the low bits of operand B.
  localparam int SHAMT_W = $clog2(XLEN);

  logic [XLEN-1:0]        operand_a;
  logic [XLEN-1:0]        operand_b;
  logic signed [XLEN-1:0] operand_a_s;
  logic signed [XLEN-1:0] operand_b_s;
  logic [SHAMT_W-1:0]     shamt;
  logic [XLEN-1:0]        alu_result;

  dp_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clock         (clock),
    .reset         (reset),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .read_data1    (operand_a),
    .read_data2    (operand_b),
    .write_reg     (write_reg),
    .write_data    (alu_result),
    .write_en      (regwrite)
  );

  assign operand_a_s = operand_a;
  assign operand_b_s = operand_b;
  assign shamt       = operand_b[SHAMT_W-1:0];

  // The result feeds straight back into the register file; since the write
  // happens only at the edge, rs == rd forms no combinational loop.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_AND:  alu_result = operand_a & operand_b;
      ALU_OR:   alu_result = operand_a | operand_b;
      ALU_ADD:  alu_result = operand_a + operand_b;
      ALU_XOR:  alu_result = operand_a ^ operand_b;
      ALU_SLL:  alu_result = operand_a << shamt;
      ALU_SRL:  alu_result = operand_a >> shamt;
      ALU_SUB:  alu_result = operand_a - operand_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, (operand_a_s < operand_b_s)};
      ALU_SRA:  alu_result = operand_a_s >>> shamt;
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      ALU_NOR:  alu_result = ~(operand_a | operand_b);
      default:  alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == '0);

endmodule : reg_alu_datapath

// File: tb/tb_reg_alu_datapath.sv
module tb_reg_alu_datapath;

  logic       clock;
  logic       reset;
  logic [4:0] read_reg_num1;
  logic [4:0] read_reg_num2;
  logic [4:0] write_reg;
  logic [3:0] alu_control;
  logic       regwrite;
  logic       zero_flag;

  int checks = 0;
  int errors = 0;

  // Architectural register state as the specification defines it.
  bit [31:0] model_regs [32];

  localparam bit [3:0] OP_AND  = 4'd0;
  localparam bit [3:0] OP_OR   = 4'd1;
  localparam bit [3:0] OP_ADD  = 4'd2;
  localparam bit [3:0] OP_XOR  = 4'd3;
  localparam bit [3:0] OP_SLL  = 4'd4;
  localparam bit [3:0] OP_SRL  = 4'd5;
  localparam bit [3:0] OP_SUB  = 4'd6;
  localparam bit [3:0] OP_SLT  = 4'd7;
  localparam bit [3:0] OP_SRA  = 4'd8;
  localparam bit [3:0] OP_SLTU = 4'd9;
  localparam bit [3:0] OP_NOR  = 4'd12;

  reg_alu_datapath dut (
    .clock         (clock),
    .reset         (reset),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .zero_flag     (zero_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic bit [31:0] model_read(input bit [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : model_regs[idx];
  endfunction

  // Reference ALU from plain unsigned arithmetic: signed compare by biasing
  // the sign bit, arithmetic shift by shifting a sign-extended 64-bit value.
  function automatic bit [31:0] ref_alu(input bit [31:0] a, input bit [31:0] b, input bit [3:0] op);
    bit [63:0] ext;
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a * (32'd1 << sh);
      4'd5:  return a / (32'd1 << sh);
      4'd6:  return a + (~b + 32'd1);
      4'd7:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd8: begin
        ext = {(a[31] ? 32'hFFFF_FFFF : 32'h0), a};
        ext = ext >> sh;
        return ext[31:0];
      end
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_zero();
    return ref_alu(model_read(read_reg_num1), model_read(read_reg_num2), alu_control) == 32'd0;
  endfunction

  task automatic drive(input bit [4:0] rs1, input bit [4:0] rs2, input bit [3:0] op,
                       input bit [4:0] rd, input bit we);
    read_reg_num1 = rs1;
    read_reg_num2 = rs2;
    alu_control   = op;
    write_reg     = rd;
    regwrite      = we;
    #1;
  endtask

  // Compares zero_flag against a value stated by the caller and against the
  // reference model, each as a separate comparison.
  task automatic check_zero(input string tag, input bit expected);
    checks++;
    assert (zero_flag === expected) else begin
      errors++;
      $error("FAIL %s: zero_flag observed=%b expected=%b", tag, zero_flag, expected);
    end
    checks++;
    assert (zero_flag === model_zero()) else begin
      errors++;
      $error("FAIL %s(model): zero_flag observed=%b expected=%b", tag, zero_flag, model_zero());
    end
  endtask

  // One rising edge; the model applies reset or write-back using the
  // pre-edge inputs, then outputs are sampled well after the edge.
  task automatic tick();
    bit [31:0] res;
    res = ref_alu(model_read(read_reg_num1), model_read(read_reg_num2), alu_control);
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = i;
    end else if (regwrite && write_reg != 5'd0) begin
      model_regs[write_reg] = res;
    end
    #2;
  endtask

  initial begin
    bit [3:0] ops [12];
    bit [4:0] r1, r2, rdx;
    bit [3:0] op;
    bit       we;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SRL, OP_SUB, OP_SLT,
            OP_SRA, OP_SLTU, OP_NOR, 4'd10};
    for (int i = 0; i < 32; i++) model_regs[i] = '0;

    // Reset with regwrite high: no write-back may happen.
    reset = 1'b0;
    drive(5'd1, 5'd2, OP_ADD, 5'd7, 1'b1);
    tick();
    reset = 1'b1;
    drive(5'd0, 5'd0, OP_ADD, 5'd0, 1'b0);
    check_zero("reset_x0_plus_x0", 1'b1);
    drive(5'd0, 5'd1, OP_ADD, 5'd0, 1'b0);
    check_zero("reset_x0_plus_x1", 1'b0);
    drive(5'd7, 5'd7, OP_SUB, 5'd0, 1'b0);
    check_zero("reset_x7_minus_x7", 1'b1);
    drive(5'd7, 5'd3, OP_SLTU, 5'd0, 1'b0);
    check_zero("reset_x7_ge_x3", 1'b1);
    drive(5'd7, 5'd8, OP_SLTU, 5'd0, 1'b0);
    check_zero("reset_x7_lt_x8", 1'b0);

    // Write-back: x5 = 1 + 2 = 3.
    drive(5'd1, 5'd2, OP_ADD, 5'd5, 1'b1);
    check_zero("wb_add_pre_edge", 1'b0);
    tick();
    drive(5'd5, 5'd0, OP_SUB, 5'd0, 1'b0);
    check_zero("wb_x5_minus_x0", 1'b0);
    drive(5'd5, 5'd3, OP_SUB, 5'd0, 1'b0);
    check_zero("wb_x5_eq_x3", 1'b1);

    // x0 ignores writes.
    drive(5'd7, 5'd0, OP_OR, 5'd0, 1'b1);
    tick();
    drive(5'd0, 5'd0, OP_ADD, 5'd0, 1'b0);
    check_zero("x0_protected", 1'b1);

    // x9 = 0 - 1 = 0xFFFFFFFF.
    drive(5'd0, 5'd1, OP_SUB, 5'd9, 1'b1);
    tick();
    drive(5'd9, 5'd1, OP_SLT, 5'd0, 1'b0);
    check_zero("slt_neg_lt_one", 1'b0);
    drive(5'd9, 5'd1, OP_SLTU, 5'd0, 1'b0);
    check_zero("sltu_max_ge_one", 1'b1);
    drive(5'd9, 5'd1, OP_ADD, 5'd0, 1'b0);
    check_zero("add_wraps", 1'b1);
    drive(5'd9, 5'd31, OP_SRA, 5'd0, 1'b0);
    check_zero("sra_sign_fill", 1'b0);
    drive(5'd9, 5'd31, OP_SRL, 5'd0, 1'b0);
    check_zero("srl_by_31", 1'b0);
    drive(5'd1, 5'd31, OP_SLL, 5'd0, 1'b0);
    check_zero("sll_by_31", 1'b0);
    drive(5'd2, 5'd31, OP_SLL, 5'd0, 1'b0);
    check_zero("sll_out_top", 1'b1);
    drive(5'd9, 5'd9, OP_NOR, 5'd0, 1'b0);
    check_zero("nor_all_ones", 1'b1);
    drive(5'd0, 5'd0, OP_NOR, 5'd0, 1'b0);
    check_zero("nor_zeros", 1'b0);
    drive(5'd9, 5'd9, 4'd10, 5'd0, 1'b0);
    check_zero("undefined_op", 1'b1);
    drive(5'd9, 5'd6, OP_AND, 5'd0, 1'b0);
    check_zero("and_mask", 1'b0);
    drive(5'd9, 5'd6, OP_XOR, 5'd0, 1'b0);
    check_zero("xor_value", 1'b0);

    // Read-during-write: x4 = x4 + x4 with the old value 4.
    drive(5'd4, 5'd4, OP_ADD, 5'd4, 1'b1);
    check_zero("rdw_pre_edge", 1'b0);
    tick();
    drive(5'd4, 5'd2, OP_SUB, 5'd0, 1'b0);
    check_zero("rdw_x4_minus_x2", 1'b0);
    drive(5'd4, 5'd8, OP_SUB, 5'd0, 1'b0);
    check_zero("rdw_x4_is_8", 1'b1);
    drive(5'd4, 5'd4, OP_ADD, 5'd4, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    drive(5'd4, 5'd8, OP_SUB, 5'd0, 1'b0);
    check_zero("regwrite_gating", 1'b1);

    // Reset mid-operation beats a pending write to x6.
    reset = 1'b0;
    drive(5'd9, 5'd0, OP_OR, 5'd6, 1'b1);
    tick();
    reset = 1'b1;
    drive(5'd5, 5'd5, OP_SUB, 5'd0, 1'b0);
    check_zero("midreset_x5_sub_self", 1'b1);
    drive(5'd5, 5'd3, OP_SUB, 5'd0, 1'b0);
    check_zero("midreset_x5_not_3", 1'b0);
    drive(5'd5, 5'd4, OP_SLTU, 5'd0, 1'b0);
    check_zero("midreset_x5_ge_4", 1'b1);
    drive(5'd5, 5'd6, OP_SLTU, 5'd0, 1'b0);
    check_zero("midreset_x5_lt_x6", 1'b0);
    drive(5'd6, 5'd7, OP_SLTU, 5'd0, 1'b0);
    check_zero("midreset_x6_lt_x7", 1'b0);
    drive(5'd6, 5'd5, OP_SLTU, 5'd0, 1'b0);
    check_zero("midreset_x6_ge_x5", 1'b1);
    drive(5'd4, 5'd8, OP_SUB, 5'd0, 1'b0);
    check_zero("midreset_x4_not_8", 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r1  = 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 4) == 0) ? r1 : 5'($urandom_range(0, 31));
      rdx = 5'($urandom_range(0, 31));
      op  = ops[$urandom_range(0, 11)];
      we  = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      drive(r1, r2, op, rdx, we);
      checks++;
      assert (zero_flag === model_zero()) else begin
        errors++;
        $error("FAIL rand[%0d] op=%0d rs1=%0d rs2=%0d: zero_flag observed=%b expected=%b",
               n, op, r1, r2, zero_flag, model_zero());
      end
      tick();
    end
    reset = 1'b1;

    // Sweep every register against itself and its neighbour after the run.
    for (int i = 1; i < 32; i++) begin
      drive(5'(i), 5'(i - 1), OP_SUB, 5'd0, 1'b0);
      checks++;
      assert (zero_flag === model_zero()) else begin
        errors++;
        $error("FAIL sweep[%0d]: zero_flag observed=%b expected=%b", i, zero_flag, model_zero());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_alu_datapath
